pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush and hazard-field conditioning. It is the generic successor to the fixed EX/MEM latch. One instance sits between each pair of adjacent stages (ID/EX, EX/MEM, MEM/WB). It carries PC, instruction, a DATA_W-bit payload and the forwarding/stall fields (write enable, write address, Tnew). An optional skid entry lets `in_ready` come straight from a flop.

---
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready handshake,
// synchronous flush and hazard-field conditioning (Tnew decrement, WE masking for $0).
// Optional skid entry enabled by defining PIPE_SKID_EN; the default build has none.
// Whenever out_valid is 0 the output fields hold the bubble encoding, so hazard logic
// can use them without qualifying by valid.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TNEW_W   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    input  logic [4:0]        in_wa,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    output logic [4:0]        out_wa,
    output logic [TNEW_W-1:0] out_tnew
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic [4:0]        wa;
        logic [TNEW_W-1:0] tnew;
    } entry_t;

    function automatic entry_t bubble_entry();
        entry_t e;
        e    = '0;
        e.pc = RESET_PC;
        return e;
    endfunction

    entry_t main_q, main_d;
    logic   valid_q, valid_d;
    entry_t in_entry;
    logic   out_free;

    // Condition the incoming fields: saturating Tnew decrement, no write hazard on $0
    always_comb begin
        in_entry       = '0;
        in_entry.pc    = in_pc;
        in_entry.instr = in_instr;
        in_entry.data  = in_data;
        in_entry.we    = in_we && (in_wa != 5'd0);
        in_entry.wa    = in_wa;
        in_entry.tnew  = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
    end

    // Main register is free to change when empty or when its content is being taken
    assign out_free = !valid_q || out_ready;

`ifdef PIPE_SKID_EN

    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_fire;

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;

    // Next state: skid drains first into main to keep FIFO order; stalled inputs land in skid
    always_comb begin
        valid_d      = valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            valid_d      = 1'b0;
            main_d       = bubble_entry();
            skid_valid_d = 1'b0;
            skid_d       = bubble_entry();
        end else if (out_free) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
                skid_d       = bubble_entry();
            end else if (in_fire) begin
                valid_d = 1'b1;
                main_d  = in_entry;
            end else begin
                valid_d = 1'b0;
                main_d  = bubble_entry();
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = in_entry;
        end
    end

    // Skid entry state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
            skid_q       <= bubble_entry();
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

`else

    assign in_ready = out_free;

    // Next state: load on a free slot, bubble when nothing arrives, hold when stalled
    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
            main_d  = bubble_entry();
        end else if (out_free) begin
            if (in_valid) begin
                valid_d = 1'b1;
                main_d  = in_entry;
            end else begin
                valid_d = 1'b0;
                main_d  = bubble_entry();
            end
        end
    end

`endif

    // Main register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            main_q  <= bubble_entry();
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = main_q.pc;
    assign out_instr = main_q.instr;
    assign out_data  = main_q.data;
    assign out_we    = main_q.we;
    assign out_wa    = main_q.wa;
    assign out_tnew  = main_q.tnew;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stimulus side pushes hand-computed expected
// entries on each accepted input; a monitor compares the output against the queue head.
module tb_pipe_stage_reg;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef PIPE_SKID_EN
    localparam bit Skid = 1'b1;
`else
    localparam bit Skid = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [63:0] in_data;
    logic        in_we;
    logic [4:0]  in_wa;
    logic [1:0]  in_tnew;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [63:0] out_data;
    logic        out_we;
    logic [4:0]  out_wa;
    logic [1:0]  out_tnew;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_data   (in_data),
        .in_we     (in_we),
        .in_wa     (in_wa),
        .in_tnew   (in_tnew),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_data  (out_data),
        .out_we    (out_we),
        .out_wa    (out_wa),
        .out_tnew  (out_tnew)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [63:0] data;
        logic        we;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic        exp_we;
        logic [1:0]  exp_tnew;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [63:0] data;
        logic        we;
        logic [4:0]  wa;
        logic [1:0]  tnew;
    } exp_t;

    vec_t vec [12];
    exp_t sb [$];
    int   cur;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int idx);
        cur      = idx;
        in_valid = 1'b1;
        in_pc    = vec[idx].pc;
        in_instr = vec[idx].instr;
        in_data  = vec[idx].data;
        in_we    = vec[idx].we;
        in_wa    = vec[idx].wa;
        in_tnew  = vec[idx].tnew;
    endtask

    // Scoreboard push: accepted inputs queue their expected outputs; flush drops all
    always @(negedge clk) begin
        #2;
        if (reset_n === 1'b1) begin
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back({vec[cur].pc, vec[cur].instr, vec[cur].data,
                              vec[cur].exp_we, vec[cur].wa, vec[cur].exp_tnew});
            end
        end
    end

    // Monitor: valid output must match the queue head; a bubble must be bubble-encoded
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %0h expected no valid output", out_pc);
            end else begin
                chk("out_pc", out_pc, sb[0].pc);
                chk("out_we", out_we, sb[0].we);
                chk("out_tnew", out_tnew, sb[0].tnew);
                chk("out_instr_data_wa", {out_instr, out_data, out_wa},
                    {sb[0].instr, sb[0].data, sb[0].wa});
                if (out_ready) void'(sb.pop_front());
            end
        end else begin
            chk("bubble_pc", out_pc, RST_PC);
            chk("bubble_fields", {out_instr, out_data, out_we, out_wa, out_tnew}, '0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            pc            instr         data          we    wa     tn    ewe   etn
        vec[0]  = {32'h3004, 32'h0000_0011, 64'h1111, 1'b1, 5'd5,  2'd2, 1'b1, 2'd1};
        vec[1]  = {32'h3008, 32'h0000_0022, 64'h2222, 1'b1, 5'd0,  2'd1, 1'b0, 2'd0};
        vec[2]  = {32'h300c, 32'h0000_0033, 64'h3333, 1'b1, 5'd7,  2'd0, 1'b1, 2'd0};
        vec[3]  = {32'h3014, 32'h0000_0044, 64'h4444, 1'b1, 5'd9,  2'd0, 1'b1, 2'd0};
        vec[4]  = {32'h3020, 32'h0000_0055, 64'h5555, 1'b1, 5'd3,  2'd3, 1'b1, 2'd2};
        vec[5]  = {32'h3024, 32'h0000_0066, 64'h6666, 1'b0, 5'd4,  2'd1, 1'b0, 2'd0};
        vec[6]  = {32'h3028, 32'h0000_0077, 64'h7777, 1'b1, 5'd31, 2'd2, 1'b1, 2'd1};
        vec[7]  = {32'h3030, 32'h0000_0088, 64'h8888, 1'b1, 5'd1,  2'd1, 1'b1, 2'd0};
        vec[8]  = {32'h3034, 32'h0000_0099, 64'h9999, 1'b1, 5'd2,  2'd2, 1'b1, 2'd1};
        vec[9]  = {32'h3038, 32'h0000_00aa, 64'haaaa, 1'b1, 5'd6,  2'd3, 1'b1, 2'd2};
        vec[10] = {32'h3010, 32'h0000_00bb, 64'hbbbb, 1'b1, 5'd8,  2'd2, 1'b1, 2'd1};
        vec[11] = {32'h303c, 32'h0000_00cc, 64'hcccc, 1'b1, 5'd10, 2'd1, 1'b1, 2'd0};

        n_tests   = 0;
        n_fail    = 0;
        cur       = 0;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        in_data   = '0;
        in_we     = 1'b0;
        in_wa     = '0;
        in_tnew   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, RST_PC);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fields", {out_we, out_tnew, out_wa}, '0);
        #5 reset_n = 1'b1;

        // Streaming with conditioning, no bubbles
        for (int i = 0; i < 4; i++) begin
            cyc();
            set_in(i);
            @(negedge clk);
            if (i > 0) chk("stream_no_bubble", out_valid, 1'b1);
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", out_valid, 1'b1);
        cyc();
        @(negedge clk);
        chk("stream_drained", out_valid, 1'b0);

        // Stall for three cycles with input offered
        cyc();
        set_in(4);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_a_in_ready", in_ready, 1'b1);
        cyc();
        set_in(5);
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_b_in_ready", in_ready, Skid);
        chk("stall_b_pc", out_pc, 32'h3020);
        cyc();
        if (Skid) set_in(6);
        @(negedge clk);
        chk("stall_c_in_ready", in_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk("stall_d_in_ready", in_ready, 1'b0);
        chk("stall_d_tnew_held", out_tnew, 2'd2);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_e_in_ready", in_ready, !Skid);
        cyc();
        if (!Skid) in_valid = 1'b0;
        @(negedge clk);
        chk("stall_f_in_ready", in_ready, 1'b1);
        chk("stall_f_pc", out_pc, 32'h3024);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_g_valid", out_valid, Skid);
        cyc();
        @(negedge clk);

        // Flush with stalled (and skid-full) stage and input offered
        cyc();
        set_in(7);
        out_ready = 1'b0;
        cyc();
        set_in(8);
        @(negedge clk);
        chk("flush_pre_in_ready", in_ready, Skid);
        cyc();
        set_in(9);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_pc", out_pc, RST_PC);
        chk("flush_out_we", out_we, 1'b0);
        chk("flush_post_in_ready", in_ready, 1'b1);
        // Flush on an empty stage: in_ready stays high but the input is dropped
        cyc();
        set_in(9);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_empty_in_ready", in_ready, 1'b1);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_valid", out_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk("flush_drop_valid2", out_valid, 1'b0);

        // Asynchronous reset while stalled on PC 3010
        cyc();
        set_in(10);
        out_ready = 1'b1;
        cyc();
        set_in(11);
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_pc_3010", out_pc, 32'h3010);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_pc_3010_b", out_pc, 32'h3010);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_pc", out_pc, RST_PC);
        chk("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        #3;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("postrst_pc", out_pc, RST_PC);
            chk("postrst_valid", out_valid, 1'b0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
